// File: rtl/nested_int_ctrl_if.sv
// Interrupt controller <-> CPU bundle: raw requests, masks, accept/return strobes and presentation.
// Latency: n/a (wires only).
// Backpressure: none; a presented interrupt is held until the CPU accepts it with int_ack.
interface nested_int_ctrl_if #(
    parameter int unsigned N_CH   = 3,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned ID_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned DEPTH_W = $clog2(N_CH + 1);

    // Request side
    logic [N_CH-1:0]    inter;
    logic [N_CH-1:0]    int_en;
    logic               gie;
    logic               int_ack;
    logic               eret;

    // Presentation side
    logic               int_req;
    logic [ID_W-1:0]    int_id;
    logic [ADDR_W-1:0]  int_vec;
    logic [N_CH-1:0]    inter_running;
    logic [DEPTH_W-1:0] nest_depth;

    // CPU / environment view
    modport master (
        output inter, int_en, gie, int_ack, eret,
        input  int_req, int_id, int_vec, inter_running, nest_depth
    );

    // Controller view
    modport slave (
        input  inter, int_en, gie, int_ack, eret,
        output int_req, int_id, int_vec, inter_running, nest_depth
    );
endinterface

// File: rtl/nested_int_ctrl.sv
// Nested, fixed-priority interrupt controller with edge-triggered requests and an in-service stack.
// Latency: an input edge is registered on one clock and presented combinationally right after that edge.
// Backpressure: none; pending requests wait (no queueing of repeats) until acked and higher than cur_pri.
module nested_int_ctrl #(
    parameter int unsigned       N_CH       = 3,
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(32'h0000_0100),
    parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(32'h0000_0040)
) (
    input  logic               clk,
    input  logic               clr,
    nested_int_ctrl_if.slave   bus
);
    localparam int unsigned ID_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned DEPTH_W = $clog2(N_CH + 1);

    // State
    logic [N_CH-1:0]    inter_q,   inter_d;     // previous sample of the raw request lines
    logic [N_CH-1:0]    pending_q, pending_d;   // latched edges awaiting acceptance
    logic [N_CH-1:0]    running_q, running_d;   // in-service bits (one per nesting level)
    logic [DEPTH_W-1:0] depth_q,   depth_d;     // popcount of running_q, tracked incrementally

    // Combinational decode
    logic [N_CH-1:0]    rise;
    logic [N_CH-1:0]    eligible;
    logic               cand_vld;
    logic [ID_W-1:0]    cand_idx;
    logic               run_vld;
    logic [ID_W-1:0]    run_idx;
    logic               int_req;
    logic               ack_take;
    logic               eret_take;

    // Rising-edge detect against the registered copy of each request line
    assign rise     = bus.inter & ~inter_q;
    assign eligible = pending_q & bus.int_en;

    // Highest eligible pending channel (later iterations override, so highest index wins)
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (eligible[i]) begin
                cand_vld = 1'b1;
                cand_idx = ID_W'(i);
            end
        end
    end

    // Current priority level: highest in-service channel; run_vld=0 stands for "-1"
    always_comb begin
        run_vld = 1'b0;
        run_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (running_q[i]) begin
                run_vld = 1'b1;
                run_idx = ID_W'(i);
            end
        end
    end

    // Present only a strictly higher-priority candidate, and only with interrupts globally enabled
    always_comb begin
        int_req = bus.gie & cand_vld & (~run_vld | (cand_idx > run_idx));
    end

    assign bus.int_req       = int_req;
    assign bus.int_id        = int_req ? cand_idx : '0;
    assign bus.int_vec       = int_req ? (VEC_BASE + ADDR_W'(cand_idx) * VEC_STRIDE) : '0;
    assign bus.inter_running = running_q;
    assign bus.nest_depth    = depth_q;

    // Next-state: eret pops the top level, ack pushes the presented channel, new edges set pending last
    always_comb begin
        inter_d   = bus.inter;
        pending_d = pending_q;
        running_d = running_q;

        // int_req is the pre-edge view, so an ack in the same cycle as eret still uses it
        ack_take  = bus.int_ack & int_req;
        eret_take = bus.eret & run_vld;

        // The acked channel is always above run_idx, so pop and push never touch the same bit
        if (eret_take) begin
            running_d[run_idx] = 1'b0;
        end
        if (ack_take) begin
            running_d[cand_idx] = 1'b1;
            pending_d[cand_idx] = 1'b0;
        end

        // A fresh edge beats a same-cycle ack of that channel
        pending_d = pending_d | rise;

        // Push and pop each move depth by one; eret with nothing in service is ignored, so no underflow
        depth_d = depth_q + DEPTH_W'(ack_take) - DEPTH_W'(eret_take);
    end

    // State registers; reset drops all pending and in-service state
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            inter_q   <= '0;
            pending_q <= '0;
            running_q <= '0;
            depth_q   <= '0;
        end else begin
            inter_q   <= inter_d;
            pending_q <= pending_d;
            running_q <= running_d;
            depth_q   <= depth_d;
        end
    end

endmodule

// File: tb/tb_nested_int_ctrl.sv
// Directed bench for nested_int_ctrl (N_CH=3): priority, nesting, masking, same-cycle corner cases, reset.
// Latency: inputs change 1 time unit after a rising edge; outputs are checked at that same offset.
// Backpressure: n/a.
module tb_nested_int_ctrl;
    logic clk;
    logic clr;
    int   n_vec;
    int   n_miss;

    nested_int_ctrl_if #(.N_CH(3), .ADDR_W(32)) bus ();

    nested_int_ctrl #(
        .N_CH      (3),
        .ADDR_W    (32),
        .VEC_BASE  (32'h0000_0100),
        .VEC_STRIDE(32'h0000_0040)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int ch);
        bus.inter[ch] = 1'b1;
        tick();
        bus.inter[ch] = 1'b0;
    endtask

    task automatic ack();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    task automatic ret();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
    endtask

    task automatic check_pres(input string tag, input logic req, input logic [31:0] id, input logic [31:0] vec);
        check({tag, ".req"}, 32'(bus.int_req), 32'(req));
        check({tag, ".id"},  32'(bus.int_id),  id);
        check({tag, ".vec"}, bus.int_vec,      vec);
    endtask

    task automatic check_run(input string tag, input logic [31:0] run, input logic [31:0] depth);
        check({tag, ".run"},   32'(bus.inter_running), run);
        check({tag, ".depth"}, 32'(bus.nest_depth),    depth);
    endtask

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        clr          = 1'b0;
        bus.inter    = 3'b000;
        bus.int_en   = 3'b111;
        bus.gie      = 1'b1;
        bus.int_ack  = 1'b0;
        bus.eret     = 1'b0;

        // Reset state
        tick();
        tick();
        check_pres("rst", 1'b0, 32'd0, 32'd0);
        check_run("rst", 32'd0, 32'd0);
        clr = 1'b1;
        tick();

        // Single request on channel 1
        pulse(1);
        check_pres("single", 1'b1, 32'd1, 32'h140);
        ack();
        check_run("single.ack", 32'b010, 32'd1);
        check("single.ack.req", 32'(bus.int_req), 32'd0);
        ret();
        check_run("single.eret", 32'b000, 32'd0);

        // Nesting 1 -> 2, then 0 waits for both returns
        pulse(1);
        ack();
        pulse(2);
        check_pres("nest.pre2", 1'b1, 32'd2, 32'h180);
        ack();
        check_run("nest.ack2", 32'b110, 32'd2);
        pulse(0);
        check("nest.ch0.blk", 32'(bus.int_req), 32'd0);
        ret();
        check_run("nest.eret1", 32'b010, 32'd1);
        check("nest.ch0.blk2", 32'(bus.int_req), 32'd0);
        ret();
        check_pres("nest.ch0", 1'b1, 32'd0, 32'h100);
        ack();
        ret();
        check_run("nest.clean", 32'b000, 32'd0);

        // Lower requests during a high handler
        pulse(2);
        ack();
        check_run("low.ack2", 32'b100, 32'd1);
        pulse(0);
        pulse(1);
        check("low.blk", 32'(bus.int_req), 32'd0);
        ret();
        check_pres("low.first", 1'b1, 32'd1, 32'h140);
        ack();
        check("low.ch0.blk", 32'(bus.int_req), 32'd0);
        ret();
        check_pres("low.second", 1'b1, 32'd0, 32'h100);
        ack();
        ret();

        // Masking keeps the request pending
        bus.int_en = 3'b011;
        pulse(2);
        tick();
        check("mask.req", 32'(bus.int_req), 32'd0);
        bus.int_en = 3'b111;
        #1;
        check_pres("mask.unmask", 1'b1, 32'd2, 32'h180);
        bus.gie = 1'b0;
        #1;
        check("mask.gie", 32'(bus.int_req), 32'd0);
        bus.gie = 1'b1;
        #1;
        ack();
        ret();
        check_run("mask.clean", 32'b000, 32'd0);

        // Same-cycle ack and eret
        pulse(0);
        ack();
        pulse(2);
        check_pres("ackeret.pre", 1'b1, 32'd2, 32'h180);
        bus.int_ack = 1'b1;
        bus.eret    = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        bus.eret    = 1'b0;
        check_run("ackeret", 32'b100, 32'd1);
        ret();
        check_run("ackeret.clean", 32'b000, 32'd0);

        // Ack together with a new edge on the same channel: edge wins
        pulse(1);
        tick();
        bus.inter[1] = 1'b1;
        bus.int_ack  = 1'b1;
        tick();
        bus.inter[1] = 1'b0;
        bus.int_ack  = 1'b0;
        check_run("ackedge", 32'b010, 32'd1);
        check("ackedge.req", 32'(bus.int_req), 32'd0);
        ret();
        check_pres("ackedge.repend", 1'b1, 32'd1, 32'h140);
        ack();
        ret();

        // Asynchronous reset mid-handler, input held high across release
        pulse(0);
        ack();
        pulse(1);
        ack();
        check_run("arst.pre", 32'b011, 32'd2);
        bus.inter[2] = 1'b1;
        tick();
        check_pres("arst.pend", 1'b1, 32'd2, 32'h180);
        #2;
        clr = 1'b0;
        #1;
        check_pres("arst", 1'b0, 32'd0, 32'd0);
        check_run("arst", 32'd0, 32'd0);
        #3;
        clr = 1'b1;
        tick();
        check_pres("arst.release", 1'b1, 32'd2, 32'h180);
        bus.inter[2] = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
